// File: rtl/router_ctrl_fsm_if.sv
//----------------------------------------------------------------------------
// Module      : router_ctrl_fsm_if
// Description : Source / FIFO / register-block signals around the router FSM.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface router_ctrl_fsm_if #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 2
);
    logic                  pkt_valid;
    logic [ADDR_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  soft_reset;
    logic                  parity_done;
    logic                  low_packet_valid;

    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic                  write_enb_reg;
    logic                  busy;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  addr_sel, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output addr_sel, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy
    );
endinterface

`default_nettype wire

// File: rtl/router_ctrl_fsm.sv
//----------------------------------------------------------------------------
// Module      : router_ctrl_fsm
// Description : 1x3 router input-path controller: header decode, FIFO
//               hold-off and per-phase strobes for the packet register block.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module router_ctrl_fsm #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 2
) (
    input wire              clock,
    input wire              reset,
    router_ctrl_fsm_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] c_NUM_PORTS = NUM_PORTS[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        S_DECODE_ADDRESS     = 3'd0,
        S_WAIT_TILL_EMPTY    = 3'd1,
        S_LOAD_FIRST_DATA    = 3'd2,
        S_LOAD_DATA          = 3'd3,
        S_FIFO_FULL_STATE    = 3'd4,
        S_LOAD_AFTER_FULL    = 3'd5,
        S_LOAD_PARITY        = 3'd6,
        S_CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr_sel;
    logic                  r_detect_add;
    logic                  r_lfd_state;
    logic                  r_ld_state;
    logic                  r_laf_state;
    logic                  r_full_state;
    logic                  r_rst_int_reg;
    logic                  r_write_enb_reg;
    logic                  r_busy;

    logic w_addr_valid;
    logic w_hdr_accept;
    logic w_soft_rst;

    assign w_addr_valid = ({1'b0, bus.data_in} < c_NUM_PORTS);
    assign w_hdr_accept = (r_state == S_DECODE_ADDRESS) && bus.pkt_valid && w_addr_valid;
    // addr_sel only ever latches a valid address, the range guard keeps the index safe
    assign w_soft_rst   = ({1'b0, r_addr_sel} < c_NUM_PORTS) && bus.soft_reset[r_addr_sel];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DECODE_ADDRESS: begin
                if (w_hdr_accept)
                    w_next = bus.fifo_empty[bus.data_in] ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
            end
            S_WAIT_TILL_EMPTY: begin
                if (bus.fifo_empty[r_addr_sel])
                    w_next = S_LOAD_FIRST_DATA;
            end
            S_LOAD_FIRST_DATA: w_next = S_LOAD_DATA;
            S_LOAD_DATA: begin
                if (bus.fifo_full)
                    w_next = S_FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    w_next = S_LOAD_PARITY;
            end
            S_FIFO_FULL_STATE: begin
                if (!bus.fifo_full)
                    w_next = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    w_next = S_DECODE_ADDRESS;
                else if (bus.low_packet_valid)
                    w_next = S_LOAD_PARITY;
                else
                    w_next = S_LOAD_DATA;
            end
            S_LOAD_PARITY: w_next = S_CHECK_PARITY_ERROR;
            S_CHECK_PARITY_ERROR: begin
                w_next = bus.fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
            end
            default: w_next = S_DECODE_ADDRESS;
        endcase

        if ((r_state != S_DECODE_ADDRESS) && w_soft_rst)
            w_next = S_DECODE_ADDRESS;
    end

    // Outputs are decoded from the next state so they are registered yet
    // still line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_DECODE_ADDRESS;
            r_addr_sel      <= '0;
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_laf_state     <= 1'b0;
            r_full_state    <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hdr_accept)
                r_addr_sel <= bus.data_in;
            r_detect_add    <= (w_next == S_DECODE_ADDRESS);
            r_lfd_state     <= (w_next == S_LOAD_FIRST_DATA);
            r_ld_state      <= (w_next == S_LOAD_DATA);
            r_laf_state     <= (w_next == S_LOAD_AFTER_FULL);
            r_full_state    <= (w_next == S_FIFO_FULL_STATE);
            r_rst_int_reg   <= (w_next == S_CHECK_PARITY_ERROR);
            r_write_enb_reg <= (w_next == S_LOAD_FIRST_DATA) || (w_next == S_LOAD_DATA) ||
                               (w_next == S_LOAD_PARITY)     || (w_next == S_LOAD_AFTER_FULL);
            r_busy          <= !((w_next == S_DECODE_ADDRESS) || (w_next == S_LOAD_DATA));
        end
    end

    assign bus.addr_sel      = r_addr_sel;
    assign bus.detect_add    = r_detect_add;
    assign bus.lfd_state     = r_lfd_state;
    assign bus.ld_state      = r_ld_state;
    assign bus.laf_state     = r_laf_state;
    assign bus.full_state    = r_full_state;
    assign bus.rst_int_reg   = r_rst_int_reg;
    assign bus.write_enb_reg = r_write_enb_reg;
    assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_router_ctrl_fsm.sv
//----------------------------------------------------------------------------
// Module      : tb_router_ctrl_fsm
// Description : Directed scenarios plus randomized traffic against a phase model.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_router_ctrl_fsm;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    router_ctrl_fsm_if #(.NUM_PORTS(3), .ADDR_WIDTH(2)) bus ();

    router_ctrl_fsm #(.NUM_PORTS(3), .ADDR_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe vector layout: {detect, lfd, ld, laf, full, rst_int, wr_en, busy}
    localparam logic [7:0] c_DEC = 8'b1000_0000;
    localparam logic [7:0] c_WTE = 8'b0000_0001;
    localparam logic [7:0] c_LFD = 8'b0100_0011;
    localparam logic [7:0] c_LD  = 8'b0010_0010;
    localparam logic [7:0] c_FUL = 8'b0000_1001;
    localparam logic [7:0] c_LAF = 8'b0001_0011;
    localparam logic [7:0] c_LP  = 8'b0000_0011;
    localparam logic [7:0] c_CPE = 8'b0000_0101;

    // Model phases: 0 idle, 1 wait, 2 first, 3 load, 4 full, 5 after-full, 6 parity, 7 check
    int         m_ph;
    logic [1:0] m_addr;

    function automatic logic [7:0] dut_strobes();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    function automatic logic [7:0] model_strobes(int ph);
        logic [7:0] tbl [8];
        tbl = '{c_DEC, c_WTE, c_LFD, c_LD, c_FUL, c_LAF, c_LP, c_CPE};
        return tbl[ph];
    endfunction

    task automatic model_update();
        int nx;
        nx = m_ph;
        if (reset) begin
            m_ph   = 0;
            m_addr = 2'd0;
            return;
        end
        case (m_ph)
            0: if (bus.pkt_valid && int'(bus.data_in) < 3) begin
                   m_addr = bus.data_in;
                   nx = bus.fifo_empty[bus.data_in] ? 2 : 1;
               end
            1: if (bus.fifo_empty[m_addr]) nx = 2;
            2: nx = 3;
            3: if (bus.fifo_full) nx = 4; else if (!bus.pkt_valid) nx = 6;
            4: if (!bus.fifo_full) nx = 5;
            5: nx = bus.parity_done ? 0 : (bus.low_packet_valid ? 6 : 3);
            6: nx = 7;
            default: nx = bus.fifo_full ? 4 : 0;
        endcase
        if (m_ph != 0 && int'(m_addr) < 3 && bus.soft_reset[m_addr]) nx = 0;
        m_ph = nx;
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid        = 1'b0;
        bus.data_in          = 2'd0;
        bus.fifo_full        = 1'b0;
        bus.fifo_empty       = 3'b111;
        bus.soft_reset       = 3'b000;
        bus.parity_done      = 1'b0;
        bus.low_packet_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut_strobes() !== c_DEC || bus.addr_sel !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_held strobes=%b addr=%0d expected strobes=%b addr=0",
                     dut_strobes(), bus.addr_sel, c_DEC);
        end
        reset = 1'b0;
        bus.pkt_valid = 1'b0;
        tick();
        n_checks++;
        if (dut_strobes() !== c_DEC || bus.addr_sel !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_release strobes=%b addr=%0d expected strobes=%b addr=0",
                     dut_strobes(), bus.addr_sel, c_DEC);
        end
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_seq [7];
        int we_cnt;
        int ri_cnt;
        exp_seq = '{c_LFD, c_LD, c_LD, c_LD, c_LP, c_CPE, c_DEC};
        we_cnt = 0;
        ri_cnt = 0;
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;   // low bits of header 8'h0D
        for (int i = 0; i < 7; i++) begin
            if (i == 4) bus.pkt_valid = 1'b0;
            tick();
            we_cnt += int'(bus.write_enb_reg);
            ri_cnt += int'(bus.rst_int_reg);
            n_checks++;
            if (dut_strobes() !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL good_pkt_step%0d strobes=%b expected=%b", i, dut_strobes(), exp_seq[i]);
            end
        end
        n_checks++;
        if (we_cnt != 5 || ri_cnt != 1 || bus.addr_sel !== 2'd1) begin
            n_errors++;
            $display("FAIL good_pkt_totals wr_en=%0d rst_int=%0d addr=%0d expected 5 1 1",
                     we_cnt, ri_cnt, bus.addr_sel);
        end
    endtask

    task automatic test_busy_fifo();
        idle_inputs();
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'd2;
        bus.fifo_empty = 3'b011;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_strobes() !== c_WTE) begin
                n_errors++;
                $display("FAIL busy_fifo_wait%0d strobes=%b expected=%b", i, dut_strobes(), c_WTE);
            end
        end
        bus.fifo_empty = 3'b111;
        tick();
        n_checks++;
        if (dut_strobes() !== c_LFD || bus.addr_sel !== 2'd2) begin
            n_errors++;
            $display("FAIL busy_fifo_release strobes=%b addr=%0d expected=%b addr=2",
                     dut_strobes(), bus.addr_sel, c_LFD);
        end
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (dut_strobes() !== c_DEC) begin
            n_errors++;
            $display("FAIL busy_fifo_drain strobes=%b expected=%b", dut_strobes(), c_DEC);
        end
    endtask

    task automatic test_full_mid_packet();
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        tick();
        tick();
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_strobes() !== c_FUL) begin
                n_errors++;
                $display("FAIL full_hold%0d strobes=%b expected=%b", i, dut_strobes(), c_FUL);
            end
        end
        bus.fifo_full = 1'b0;
        tick();
        n_checks++;
        if (dut_strobes() !== c_LAF) begin
            n_errors++;
            $display("FAIL full_after strobes=%b expected=%b", dut_strobes(), c_LAF);
        end
        tick();
        n_checks++;
        if (dut_strobes() !== c_LD) begin
            n_errors++;
            $display("FAIL full_resume strobes=%b expected=%b", dut_strobes(), c_LD);
        end
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_soft_reset();
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        tick();
        tick();
        bus.fifo_full  = 1'b1;
        tick();
        bus.soft_reset = 3'b100;
        tick();
        n_checks++;
        if (dut_strobes() !== c_FUL) begin
            n_errors++;
            $display("FAIL soft_rst_other strobes=%b expected=%b", dut_strobes(), c_FUL);
        end
        bus.soft_reset = 3'b010;
        tick();
        n_checks++;
        if (dut_strobes() !== c_DEC || bus.addr_sel !== 2'd1) begin
            n_errors++;
            $display("FAIL soft_rst_sel strobes=%b addr=%0d expected=%b addr=1",
                     dut_strobes(), bus.addr_sel, c_DEC);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_invalid_addr();
        logic [1:0] prev;
        prev = bus.addr_sel;
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_strobes() !== c_DEC || bus.addr_sel !== prev) begin
                n_errors++;
                $display("FAIL invalid_addr%0d strobes=%b addr=%0d expected=%b addr=%0d",
                         i, dut_strobes(), bus.addr_sel, c_DEC, prev);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] exp_s;
        for (int i = 0; i < 600; i++) begin
            reset                = ($urandom_range(0, 99) == 0);
            bus.pkt_valid        = ($urandom_range(0, 3) != 0);
            bus.data_in          = 2'($urandom_range(0, 3));
            bus.fifo_full        = ($urandom_range(0, 4) == 0);
            bus.fifo_empty       = 3'($urandom_range(0, 7));
            bus.soft_reset       = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus.parity_done      = ($urandom_range(0, 3) == 0);
            bus.low_packet_valid = ($urandom_range(0, 3) == 0);
            tick();
            exp_s = model_strobes(m_ph);
            n_checks++;
            if (dut_strobes() !== exp_s || bus.addr_sel !== m_addr) begin
                n_errors++;
                $display("FAIL random_cyc%0d strobes=%b addr=%0d expected=%b addr=%0d",
                         i, dut_strobes(), bus.addr_sel, exp_s, m_addr);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ph     = 0;
        m_addr   = 2'd0;
        reset    = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_good_packet();
        test_busy_fifo();
        test_full_mid_packet();
        test_soft_reset();
        test_invalid_addr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Control state machine for the 1x3 router input path; sequences the packet register block and the three destination FIFOs.
- Decodes the header address, holds off the source (busy) while a FIFO is full or still draining, and asserts the per-phase strobes the register block consumes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Generates write_enb_reg for the selected FIFO.
- Sits between the router top-level input, the FIFO sync/mux logic and the register block.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; addresses 0..NUM_PORTS-1 are valid.
- ADDR_WIDTH, 2, width of the header address field, data_in[ADDR_WIDTH-1:0].

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous active-high reset.
- pkt_valid  input  1  source asserts for header and payload bytes; deasserts on the parity byte.
- data_in  input  ADDR_WIDTH  header address bits, sampled in DECODE_ADDRESS only.
- fifo_full  input  1  full flag of the currently selected FIFO (already muxed).
- fifo_empty  input  NUM_PORTS  per-FIFO empty flags.
- soft_reset  input  NUM_PORTS  per-FIFO soft-reset (read-timeout) pulses.
- parity_done  input  1  from register block: parity byte captured.
- low_packet_valid  input  1  from register block: pkt_valid fell while in full_state.
- addr_sel  output  ADDR_WIDTH  latched destination address, drives FIFO write select.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  phase strobes.
- write_enb_reg  output  1  FIFO write enable.
- busy  output  1  source must hold its current byte.

Behaviour:
- States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR. State is registered; all strobe outputs are Moore, decoded from the current state.
- Reset (synchronous, reset=1 at a rising edge): state=DECODE_ADDRESS, addr_sel=0. Resulting outputs: detect_add=1; all other strobes, write_enb_reg and busy = 0. Reset overrides every transition.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in < NUM_PORTS, fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, valid address, FIFO not empty -> WAIT_TILL_EMPTY.
  - Otherwise stay. Address 2'b11 is dropped: stay, no latch.
  - addr_sel <= data_in in the same cycle as either exit transition.
- WAIT_TILL_EMPTY: fifo_empty[addr_sel]=1 -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA, priority order:
  1. fifo_full=1 -> FIFO_FULL_STATE.
  2. pkt_valid=0 -> LOAD_PARITY.
  3. Otherwise stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_packet_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset: soft_reset[addr_sel]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle. It takes priority over all transitions except hard reset. soft_reset bits for non-selected ports are ignored.
- Output decode:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_FIRST_DATA | LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Latency: the header accepted at edge N gives lfd_state=1 in cycle N+1 and ld_state=1 from N+2.
- addr_sel holds its value until the next accepted header or reset.

Test Plan:
- Reset held 2 cycles, then released, pkt_valid=0 -> detect_add=1, busy=0, write_enb_reg=0, addr_sel=0.
- Good packet: header 8'h0D (len 3, addr 1), fifo_empty=3'b111, pkt_valid high for 4 cycles then low -> state sequence DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE. write_enb_reg=1 for 5 cycles, rst_int_reg=1 for 1 cycle, addr_sel=1.
- Busy FIFO: header addr 2, fifo_empty=3'b011 for 4 cycles then 3'b111 -> WAIT_TILL_EMPTY for 4 cycles with busy=1, then lfd_state=1.
- Full mid-packet: fifo_full=1 for 3 cycles during LOAD_DATA -> full_state=1 and busy=1 for 3 cycles. Then laf_state=1 for 1 cycle. With low_packet_valid=0 and parity_done=0, return to ld_state=1.
- Soft reset: soft_reset=3'b010 with addr_sel=1 while in FIFO_FULL_STATE -> detect_add=1 on the next cycle. soft_reset=3'b100 in the same situation -> no effect.
- Invalid address: header data_in=2'b11 with pkt_valid=1 -> remains in DECODE_ADDRESS, addr_sel unchanged, write_enb_reg=0.
